// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arbiter shared types and helpers.
// State encoding plus round-robin index wrap.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Next index after idx, wrapping n-1 back to 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry skid buffer with registered outputs.
// Upstream ready depends only on occupancy.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_val,
  output logic         in_rdy,
  output logic [W-1:0] out_data,
  output logic         out_val,
  input  logic         out_rdy
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  // Handshakes and registered-output views of the storage.
  always_comb begin
    in_rdy   = (cnt != 2'd2);
    out_val  = (cnt != 2'd0);
    out_data = mem[rp];
    push     = in_val & in_rdy;
    pop      = out_val & out_rdy;
  end

  // Pointer and occupancy tracking; reset empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  // Data storage needs no reset; occupancy qualifies it.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin FIFO write-port arbiter with burst locking.
// Define FIFO_WR_ARB_SKID_EN to register outputs via skid_buf.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N         = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_val,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_rdy,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [$clog2(N)-1:0] out_src,
  output logic                 locked
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t     state;
  arb_state_t     state_n;
  logic [SW-1:0]  ptr;
  logic [SW-1:0]  ptr_n;
  logic [SW-1:0]  owner;
  logic [SW-1:0]  owner_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic [SW-1:0]  sel;
  logic           grant;
  logic           arb_rdy;
  logic           xfer;
  logic           last_in;
  logic [WIDTH-1:0] arb_data;

  // Pick the requester: owner when locked, else rotate from ptr.
  always_comb begin
    int   idx;
    logic found;
    sel   = ptr;
    found = 1'b0;
    idx   = 0;
    if (state == LOCKED) begin
      sel = owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!found && in_val[idx]) begin
          sel   = SW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  // Grant, data mux and the one ready bit for the selected source.
  always_comb begin
    grant    = in_val[sel] & ~reset;
    arb_data = in_data[int'(sel)*WIDTH +: WIDTH];
    last_in  = in_last[sel];
    xfer     = grant & arb_rdy;
    in_rdy   = '0;
    in_rdy[sel] = xfer;
  end

  // Next-state: lock on a multi-beat packet, release on last or cap.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    if (xfer) begin
      unique case (1'b1)
        (state == IDLE): begin
          if (last_in || MAX_BURST == 1) begin
            ptr_n = SW'(rr_next(int'(sel), N));
          end else begin
            state_n = LOCKED;
            owner_n = sel;
            cnt_n   = CW'(1);
          end
        end
        (state == LOCKED): begin
          if (last_in || int'(cnt) + 1 == MAX_BURST) begin
            state_n = IDLE;
            ptr_n   = SW'(rr_next(int'(owner), N));
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Arbiter state registers; reset drops any lock at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

  assign locked = (state == LOCKED);

`ifdef FIFO_WR_ARB_SKID_EN
  logic [WIDTH+SW-1:0] sb_out;
  logic                sb_val;

  skid_buf #(
    .W(WIDTH + SW)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  ({sel, arb_data}),
    .in_val   (grant),
    .in_rdy   (arb_rdy),
    .out_data (sb_out),
    .out_val  (sb_val),
    .out_rdy  (out_rdy)
  );

  // Registered outputs; source index forced to 0 when idle.
  always_comb begin
    out_val  = sb_val;
    out_data = sb_out[WIDTH-1:0];
    out_src  = sb_val ? sb_out[WIDTH+SW-1:WIDTH] : '0;
  end
`else
  // Straight-through path from the selected requester to the FIFO.
  always_comb begin
    arb_rdy  = out_rdy;
    out_val  = grant;
    out_data = arb_data;
    out_src  = grant ? sel : '0;
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter sharing one FIFO write port among N valid/ready requester streams, with burst locking. Sits directly in front of a `fifo` instance: its output stream drives the FIFO's `data_in`/`data_in_val`/`data_in_rdy`. A granted requester keeps the port until it signals `in_last` or has moved MAX_BURST beats, so its packets stay contiguous in the FIFO.

## Interface
- WIDTH, 32, data width per beat
- N, 4, number of requesters (N >= 2, need not be a power of 2)
- MAX_BURST, 8, maximum beats per grant (>= 1)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_data  in  N*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- in_val  in  N  requester valid
- in_last  in  N  requester end-of-packet, sampled only on an accepted beat
- in_rdy  out  N  requester ready; at most one bit high
- out_data  out  WIDTH  data to FIFO
- out_val  out  1  valid to FIFO
- out_rdy  in  1  FIFO ready (FIFO data_in_rdy)
- out_src  out  $clog2(N)  index of the requester whose beat is on out_data; 0 when out_val=0
- locked  out  1  high while in LOCKED state

## Operation
- State: `IDLE`, `LOCKED`. Registers: `ptr` (next-priority index, 0..N-1), `owner`, `cnt` (width $clog2(MAX_BURST+1)).
- IDLE: `sel` = first i with in_val[i]=1, searching ptr, ptr+1, … wrapping N-1→0. No valid → no grant, out_val=0.
- LOCKED: `sel` = owner only. Other requesters get in_rdy=0 regardless of valid.
- Grant/handshake, base build: out_val = in_val[sel]; out_data = in_data[sel]; in_rdy[sel] = out_rdy; all other in_rdy = 0. A beat transfers when out_val && out_rdy.
- Transitions on a transferred beat:
  - IDLE, in_last[sel]=1 or MAX_BURST=1: stay IDLE; ptr ← (sel+1) mod N.
  - IDLE otherwise: → LOCKED; owner ← sel; cnt ← 1.
  - LOCKED, in_last[owner]=1 or cnt+1 = MAX_BURST: → IDLE; ptr ← (owner+1) mod N; cnt ← 0.
  - LOCKED otherwise: cnt ← cnt+1.
- No beat transfers → no state, ptr or cnt change. Includes owner dropping in_val mid-burst: the lock is held with no timeout, and other requesters wait.
- FIFO full (out_rdy=0): no in_rdy high, state frozen, so arbitration is effectively re-evaluated each cycle in IDLE.
- in_val must not drop before acceptance (AXI-style). Arbitration is still well-defined if it does.

## Timing
- Reset values: state=IDLE, ptr=0, owner=0, cnt=0, out_val=0, out_src=0, locked=0, in_rdy=0.
- Reset mid-burst aborts the lock immediately. The next grant after release starts from requester 0.
- Base build: combinational path in_val/in_data → out_val/out_data and out_rdy → in_rdy. Latency 0, throughput 1 beat/cycle.
- Back-to-back grants: the cycle after a release, a different requester can transfer. No idle bubble.
- Fairness: with all N requesters continuously valid and single-beat packets, grants rotate 0,1,…,N-1,0.

## Configuration
- `FIFO_WR_ARB_SKID_EN` defined: a 2-entry skid buffer is inserted between the arbiter and the out_* ports.
  - out_val, out_data and out_src are registered. Arbiter-side ready = skid buffer not full, so in_rdy no longer depends combinationally on out_rdy.
  - Latency is 1 cycle; full throughput is kept.
  - Arbitration and state transitions advance on acceptance into the skid buffer.
  - Reset empties the buffer; out_val=0.
- Undefined: the base combinational behaviour above applies.

## Structure
- Package `fifo_wr_arb_pkg`: state enum typedef (`IDLE`, `LOCKED`) and a constant function for the round-robin next-index wrap.
- Sub-module `skid_buf` (WIDTH+$clog2(N) wide, valid/ready in and out, async active-high reset), instantiated only under `FIFO_WR_ARB_SKID_EN`.

## Test plan
- Reset, no valids → out_val=0, in_rdy=0000, locked=0; hold 5 cycles, state unchanged.
- N=4, all in_val=1, in_last=1 every beat, out_rdy=1 → out_src sequence 0,1,2,3,0,1 on consecutive cycles.
- Requester 2 sends a 3-beat packet (last on beat 3) while 0 and 1 are valid → out_src 2,2,2, then 3 (if valid) or 0. locked high during beats 2–3; in_rdy[0,1]=0 throughout.
- MAX_BURST=8, requester 1 streams 20 beats with no last and 3 also valid → 8 beats from 1, then 3 gets a grant, then 1 resumes.
- Downstream FIFO full (out_rdy=0 for 4 cycles) mid-burst → no beat lost or duplicated, cnt frozen, burst resumes at the same beat.
- Assert reset during a LOCKED burst → locked=0 and in_rdy=0 in the same cycle. After release, the first grant goes to requester 0 if valid.
